// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative L1 data cache.
package dcache_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  function automatic int log2_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int va_w, input int sets, input int line_bytes);
    return va_w - $clog2(sets) - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// One access per cycle; a write cycle leaves rdata unchanged.
module sp_ram_be #(
  parameter int W     = 64,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH),
  parameter int NB    = (W + 7) / 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  input  logic [NB-1:0] be,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] wmask;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < W; b++) wmask[b] = be[b/8];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dcache_sa.sv
// N-way set-associative write-through L1 dcache: load lookup e0 -> result e1 (1 cycle).
// Writes/invalidates/flush steal the single RAM port; colliding loads report a forced miss.
module dcache_sa
  import dcache_pkg::*;
#(
  parameter int VA_W       = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 16,
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int IDX_W     = $clog2(SETS),
  localparam int TAG_W     = tag_w(VA_W, SETS, LINE_BYTES),
  localparam int WAY_W     = log2_w(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_e0,
  input  logic [VA_W-1:0]  read_addr_e0,
  input  logic             inv_en_e1,
  input  logic [IDX_W-1:0] inv_index_e1,
  input  logic             flush_all,
  output logic             flush_busy,
  input  logic             fill_xx,
  input  logic             store_xx,
  input  logic [WAY_W-1:0] store_way_xx,
  input  logic [VA_W-1:0]  write_addr_xx,
  input  logic [63:0]      write_data_xx,
  input  logic [7:0]       write_be_xx,
  output logic [VA_W-1:0]  dc_addr_e1,
  output logic [63:0]      dc_data_e1,
  output logic [WAY_W-1:0] dc_way_e1,
  output logic             dc_hit_e1,
  output logic             dc_miss_e1
);

  localparam int WPL = LINE_BYTES / 8;
  localparam int DAW = IDX_W + OFF_W - 3;

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] fcnt_q, fcnt_d;
  logic [SETS-1:0]  valid_q [WAYS];
  logic [WAY_W-1:0] victim_q [SETS];
  logic             read_e1, force_miss_e1;

  logic             flushing, do_fill, do_store, do_wr, last_beat;
  logic [IDX_W-1:0] rd_set, wr_set, e1_set;
  logic [TAG_W-1:0] wr_tag, e1_tag;
  logic [WAY_W-1:0] fill_way, wr_way;
  logic [DAW-1:0]   data_addr;
  logic [IDX_W-1:0] tag_addr;
  logic [63:0]      data_rd [WAYS];
  logic [TAG_W-1:0] tag_rd [WAYS];
  logic [WAYS-1:0]  hit_vec;

  assign flushing   = (state_q == FLUSH);
  assign flush_busy = flushing;
  assign do_fill    = fill_xx & ~flushing;
  assign do_store   = store_xx & ~fill_xx & ~flushing;
  assign do_wr      = do_fill | do_store;

  assign rd_set    = read_addr_e0[OFF_W +: IDX_W];
  assign wr_set    = write_addr_xx[OFF_W +: IDX_W];
  assign wr_tag    = write_addr_xx[VA_W-1 -: TAG_W];
  assign e1_set    = dc_addr_e1[OFF_W +: IDX_W];
  assign e1_tag    = dc_addr_e1[VA_W-1 -: TAG_W];
  assign fill_way  = victim_q[wr_set];
  assign wr_way    = do_fill ? fill_way : store_way_xx;
  assign last_beat = (write_addr_xx[OFF_W-1:0] >> 3) == OFF_W'(WPL - 1);

  // A write owns the shared RAM address for every way, not just the one written.
  assign data_addr = do_wr ? write_addr_xx[OFF_W+IDX_W-1:3] : read_addr_e0[OFF_W+IDX_W-1:3];
  assign tag_addr  = do_wr ? wr_set : rd_set;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_we;
    assign way_we = do_wr && (wr_way == WAY_W'(w));

    sp_ram_be #(.W(64), .DEPTH(SETS * WPL)) u_data (
      .clk   (clk),
      .en    (read_e0 | way_we),
      .we    (way_we),
      .addr  (data_addr),
      .wdata (write_data_xx),
      .be    (do_fill ? 8'hFF : write_be_xx),
      .rdata (data_rd[w])
    );

    sp_ram_be #(.W(TAG_W), .DEPTH(SETS)) u_tag (
      .clk   (clk),
      .en    (read_e0 | (way_we & do_fill)),
      .we    (way_we & do_fill),
      .addr  (tag_addr),
      .wdata (wr_tag),
      .be    ('1),
      .rdata (tag_rd[w])
    );

    assign hit_vec[w] = read_e1 & ~force_miss_e1 & valid_q[w][e1_set] & (tag_rd[w] == e1_tag);
  end

  always_comb begin
    dc_data_e1 = '0;
    dc_way_e1  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        dc_data_e1 = dc_data_e1 | data_rd[w];
        dc_way_e1  = dc_way_e1 | WAY_W'(w);
      end
    end
  end

  assign dc_hit_e1  = read_e1 & (|hit_vec);
  assign dc_miss_e1 = read_e1 & ~(|hit_vec);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (flush_all) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + IDX_W'(1);
        if (fcnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Later assignments override earlier ones: invalidate and flush beat a same-set fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
    end else begin
      if (do_fill) begin
        valid_q[fill_way][wr_set] <= 1'b1;
        if (last_beat) victim_q[wr_set] <= (WAYS == 1) ? '0 : fill_way + WAY_W'(1);
      end
      if (inv_en_e1)
        for (int w = 0; w < WAYS; w++) valid_q[w][inv_index_e1] <= 1'b0;
      if (flushing)
        for (int w = 0; w < WAYS; w++) valid_q[w][fcnt_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_e1       <= 1'b0;
      force_miss_e1 <= 1'b0;
      dc_addr_e1    <= '0;
    end else begin
      read_e1 <= read_e0;
      if (read_e0) begin
        dc_addr_e1    <= read_addr_e0;
        force_miss_e1 <= fill_xx | store_xx | flushing | (inv_en_e1 && (inv_index_e1 == rd_set));
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{read_addr_e0[2:0], write_addr_xx[2:0]};

  a_no_fill_store: assert property (@(posedge clk) disable iff (!reset) !(fill_xx && store_xx));
  a_onehot_hit:    assert property (@(posedge clk) disable iff (!reset) $onehot0(hit_vec));

endmodule

// File: tb/tb_dcache_sa.sv
// Randomised bench for dcache_sa against an architectural model of sets, ways and round-robin victims.
module tb_dcache_sa;

  localparam int VA_W = 32, WAYS = 2, SETS = 64, LINE_BYTES = 16;
  localparam int WPL = 2, IDX_W = 6, WAY_W = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             read_e0 = 1'b0;
  logic [VA_W-1:0]  read_addr_e0 = '0;
  logic             inv_en_e1 = 1'b0;
  logic [IDX_W-1:0] inv_index_e1 = '0;
  logic             flush_all = 1'b0;
  logic             flush_busy;
  logic             fill_xx = 1'b0;
  logic             store_xx = 1'b0;
  logic [WAY_W-1:0] store_way_xx = '0;
  logic [VA_W-1:0]  write_addr_xx = '0;
  logic [63:0]      write_data_xx = '0;
  logic [7:0]       write_be_xx = '0;
  logic [VA_W-1:0]  dc_addr_e1;
  logic [63:0]      dc_data_e1;
  logic [WAY_W-1:0] dc_way_e1;
  logic             dc_hit_e1, dc_miss_e1;

  dcache_sa #(.VA_W(VA_W), .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES)) dut (
    .clk(clk), .reset(reset), .read_e0(read_e0), .read_addr_e0(read_addr_e0),
    .inv_en_e1(inv_en_e1), .inv_index_e1(inv_index_e1), .flush_all(flush_all),
    .flush_busy(flush_busy), .fill_xx(fill_xx), .store_xx(store_xx),
    .store_way_xx(store_way_xx), .write_addr_xx(write_addr_xx),
    .write_data_xx(write_data_xx), .write_be_xx(write_be_xx), .dc_addr_e1(dc_addr_e1),
    .dc_data_e1(dc_data_e1), .dc_way_e1(dc_way_e1), .dc_hit_e1(dc_hit_e1),
    .dc_miss_e1(dc_miss_e1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: what lines the cache holds, and which way the next refill of each set takes.
  bit          m_valid  [WAYS][SETS];
  int unsigned m_tag    [WAYS][SETS];
  logic [63:0] m_data   [WAYS][SETS][WPL];
  int          m_victim [SETS];
  logic [5:0]  pool_sets [4] = '{6'h23, 6'h05, 6'h3F, 6'h00};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int unsigned tag, input logic [5:0] s, input int wd);
    return (tag << 10) | (32'(s) << 4) | (32'(wd) << 3);
  endfunction

  function automatic int lookup(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][a[9:4]] && m_tag[w][a[9:4]] == (a >> 10)) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_victim[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
    end
  endtask

  task automatic check_read(input logic [31:0] a, input bit forced, input string tag);
    int w;
    w = forced ? -1 : lookup(a);
    chk({tag, "_hit"},  64'(dc_hit_e1),  (w >= 0) ? 64'd1 : 64'd0);
    chk({tag, "_miss"}, 64'(dc_miss_e1), (w >= 0) ? 64'd0 : 64'd1);
    chk({tag, "_addr"}, 64'(dc_addr_e1), 64'(a));
    chk({tag, "_way"},  64'(dc_way_e1),  (w >= 0) ? 64'(w) : 64'd0);
    if (w >= 0) chk({tag, "_data"}, dc_data_e1, m_data[w][a[9:4]][a[3]]);
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    read_e0 = 1'b1; read_addr_e0 = a;
    @(posedge clk); #1;
    read_e0 = 1'b0;
    check_read(a, 1'b0, tag);
  endtask

  task automatic fill_line(input logic [31:0] base, input bit rd, input logic [31:0] ra);
    logic [63:0] beat [WPL];
    int s, way;
    s = base[9:4];
    for (int b = 0; b < WPL; b++) begin
      beat[b] = {$urandom, $urandom};
      fill_xx = 1'b1; write_addr_xx = {base[31:4], 4'h0} | (32'(b) << 3);
      write_data_xx = beat[b]; write_be_xx = 8'hFF;
      read_e0 = rd && (b == 0); read_addr_e0 = ra;
      @(posedge clk); #1;
      read_e0 = 1'b0;
      if (rd && b == 0) check_read(ra, 1'b1, "fill_rd");
    end
    fill_xx = 1'b0;
    way = m_victim[s];
    m_valid[way][s] = 1'b1;
    m_tag[way][s] = base >> 10;
    for (int b = 0; b < WPL; b++) m_data[way][s][b] = beat[b];
    m_victim[s] = (way + 1) % WAYS;
  endtask

  task automatic do_store(input logic [31:0] a, input int way, input logic [63:0] d,
                          input logic [7:0] be, input bit rd, input logic [31:0] ra);
    store_xx = 1'b1; store_way_xx = WAY_W'(way); write_addr_xx = a;
    write_data_xx = d; write_be_xx = be; read_e0 = rd; read_addr_e0 = ra;
    @(posedge clk); #1;
    store_xx = 1'b0; read_e0 = 1'b0;
    if (rd) check_read(ra, 1'b1, "st_rd");
    for (int i = 0; i < 8; i++)
      if (be[i]) m_data[way][a[9:4]][a[3]][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic do_inv(input logic [5:0] s, input bit rd, input logic [31:0] ra);
    inv_en_e1 = 1'b1; inv_index_e1 = s; read_e0 = rd; read_addr_e0 = ra;
    @(posedge clk); #1;
    inv_en_e1 = 1'b0; read_e0 = 1'b0;
    if (rd) check_read(ra, ra[9:4] == s, "inv_rd");
    for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #3;
    model_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // abort_at > 0 pulls reset after that many busy cycles instead of letting the flush finish.
  task automatic run_flush(input int abort_at, input logic [31:0] probe);
    int busy;
    busy = 0;
    flush_all = 1'b1;
    @(posedge clk); #1;
    flush_all = 1'b0;
    while (flush_busy === 1'b1 && busy < 200) begin
      busy++;
      if (abort_at > 0 && busy == abort_at) begin
        reset = 1'b0;
        #2;
        chk("abort_busy", 64'(flush_busy), 64'd0);
        model_reset();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", 64'(flush_busy), 64'd0);
        return;
      end
      flush_all = (busy == 5);
      read_e0 = (busy == 20); read_addr_e0 = probe;
      @(posedge clk); #1;
      if (busy == 20) check_read(probe, 1'b1, "flush_rd");
    end
    flush_all = 1'b0; read_e0 = 1'b0;
    chk("flush_cycles", 64'(busy), 64'(SETS));
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
  endtask

  initial begin
    logic [31:0] a, ra;
    logic [63:0] old;
    int w, op;
    logic [5:0] s;

    reset = 1'b1;
    #1;
    apply_reset();
    chk("rst_busy", 64'(flush_busy), 64'd0);
    chk("rst_hit",  64'(dc_hit_e1),  64'd0);
    chk("rst_miss", 64'(dc_miss_e1), 64'd0);
    chk("rst_addr", 64'(dc_addr_e1), 64'd0);
    chk("rst_way",  64'(dc_way_e1),  64'd0);

    // Line 0x1230 lands in way 0 of set 0x23; beat 1 is at 0x1238.
    fill_line(32'h0000_1230, 1'b0, '0);
    do_read(32'h0000_1238, "fill_beat1");
    chk("fill_way0", 64'(dc_way_e1), 64'd0);
    chk("fill_data", dc_data_e1, m_data[0][6'h23][1]);

    fill_line(32'h0000_2230, 1'b0, '0);
    fill_line(32'h0000_3230, 1'b0, '0);
    do_read(32'h0000_1230, "evicted");
    chk("evicted_miss", 64'(dc_miss_e1), 64'd1);
    do_read(32'h0000_2238, "keep_b");
    chk("keep_b_way", 64'(dc_way_e1), 64'd1);
    do_read(32'h0000_3230, "keep_c");
    chk("keep_c_way", 64'(dc_way_e1), 64'd0);

    old = m_data[0][6'h23][0];
    do_store(32'h0000_3230, 0, 64'hAAAA_AAAA_5555_5555, 8'h0F, 1'b0, '0);
    do_read(32'h0000_3230, "store_be");
    chk("store_merge", dc_data_e1, {old[63:32], 32'h5555_5555});

    do_inv(6'h23, 1'b1, 32'h0000_3230);
    do_read(32'h0000_3230, "after_inv");
    chk("after_inv_miss", 64'(dc_miss_e1), 64'd1);

    for (int i = 0; i < 400; i++) begin
      s  = pool_sets[$urandom_range(0, 3)];
      a  = mk($urandom_range(1, 6), s, $urandom_range(0, 1));
      ra = mk($urandom_range(1, 6), pool_sets[$urandom_range(0, 3)], $urandom_range(0, 1))
           | 32'($urandom_range(0, 7));
      op = $urandom_range(0, 9);
      w  = $urandom_range(0, WAYS - 1);
      if (op >= 4 && op <= 5 && lookup(a) < 0) begin
        fill_line(a, $urandom_range(0, 3) == 0, ra);
      end else if ((op == 6 || op == 7 || op == 9) && m_valid[w][s]) begin
        do_store(mk(m_tag[w][s], s, $urandom_range(0, 1)), w, {$urandom, $urandom},
                 8'($urandom_range(0, 255)), op == 9, ra);
      end else if (op == 8) begin
        do_inv(($urandom_range(0, 1) == 0) ? ra[9:4] : s, 1'b1, ra);
      end else begin
        do_read(ra, "rnd_rd");
      end
    end

    fill_line(32'h0000_1230, 1'b0, '0);
    fill_line(32'h0000_13F0, 1'b0, '0);
    run_flush(0, 32'h0000_13F0);
    for (int t = 1; t <= 6; t++) begin
      for (int p = 0; p < 4; p++) begin
        do_read(mk(t, pool_sets[p], 0), "post_flush");
        chk("post_flush_miss", 64'(dc_miss_e1), 64'd1);
      end
    end

    fill_line(32'h0000_1230, 1'b0, '0);
    fill_line(32'h0000_13F0, 1'b0, '0);
    fill_line(32'h0000_17F0, 1'b0, '0);
    run_flush(10, '0);
    do_read(32'h0000_13F0, "abort_rd_a");
    chk("abort_rd_a_miss", 64'(dc_miss_e1), 64'd1);
    do_read(32'h0000_17F0, "abort_rd_b");
    chk("abort_rd_b_miss", 64'(dc_miss_e1), 64'd1);
    fill_line(32'h0000_1BF0, 1'b0, '0);
    do_read(32'h0000_1BF8, "victim_reset");
    chk("victim_reset_way", 64'(dc_way_e1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
